// File: rtl/ipm_distributed_fifo_rd_stream_v1_0.sv
// ---------------------------------------------------------------------------
// ipm_distributed_fifo_rd_stream_v1_0
//
// Read-side drainer for the distributed async FIFO (read clock domain only).
// Issues fifo_rd_en against a fixed-latency FIFO read port and presents the
// returned words as a valid/ready stream through a small circular skid buffer.
// The buffer has RD_LATENCY+1 entries. That is enough to sustain one beat per
// clock, and back-pressure never drops a word that is still in flight.
//
// Parameters
//   DATA_WIDTH  data width (1..256)
//   RD_LATENCY  clocks from fifo_rd_en to valid fifo_rd_data (1 or 2)
//   LVL_W       width of buf_level (covers 0..RD_LATENCY+1)
//
// Ports
//   rd_clk        read clock
//   rd_rst_n      asynchronous reset, active low
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO read enable (combinational)
//   fifo_rd_data  FIFO read data, valid RD_LATENCY clocks after fifo_rd_en
//   flush         synchronous flush of the skid buffer and in-flight reads
//   m_valid       output word valid
//   m_ready       downstream accept
//   m_data        output word (skid buffer head entry)
//   buf_level     skid buffer occupancy
//   beat_cnt      accepted-beat counter (only with IPM_FIFO_RD_STREAM_CNT_EN)
//
// Build option: define IPM_FIFO_RD_STREAM_CNT_EN to add the beat_cnt output.
// ---------------------------------------------------------------------------
module ipm_distributed_fifo_rd_stream_v1_0 #(
    parameter  int DATA_WIDTH = 32,
    parameter  int RD_LATENCY = 1,
    localparam int LVL_W      = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_W-1:0]      buf_level
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
    ,
    output logic [31:0]           beat_cnt
`endif
);

    localparam int SKID_DEPTH = RD_LATENCY + 1;
    localparam int PTR_W      = 2;
    localparam int MEM_N      = 1 << PTR_W;  // sized to the pointer so any index is legal
    localparam int OCC_W      = 3;

    localparam logic [OCC_W-1:0] SKID_OCC = OCC_W'(SKID_DEPTH);
    localparam logic [LVL_W-1:0] SKID_LVL = LVL_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [LVL_W-1:0]      lvl_q, lvl_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_N];
    logic [DATA_WIDTH-1:0] mem_d [MEM_N];
    logic                  cap;
    logic                  pop;
    logic [OCC_W-1:0]      occ;

    assign m_valid   = (lvl_q != '0);
    assign m_data    = mem_q[rd_ptr_q];
    assign buf_level = lvl_q;

    always_comb begin
        cap = inflight_q[RD_LATENCY-1];
        pop = m_valid & m_ready;

        // Occupancy counts buffered words plus words already requested. Each
        // request therefore reserves a slot, so a returning word always fits.
        occ = OCC_W'(lvl_q);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occ = occ + OCC_W'(inflight_q[i]);
        end
        fifo_rd_en = rd_rst_n & ~fifo_empty & ~flush & ((occ - OCC_W'(pop)) < SKID_OCC);

        // The top bit falls off: it is the capture happening this cycle.
        inflight_d = RD_LATENCY'({inflight_q, fifo_rd_en});
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lvl_d      = lvl_q + LVL_W'(cap) - LVL_W'(pop);

        if (cap) begin
            mem_d[wr_ptr_q] = fifo_rd_data;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        // Flush discards buffered words and anything still returning.
        if (flush) begin
            inflight_d = '0;
            lvl_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_q <= '0;
            lvl_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < MEM_N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            lvl_q      <= lvl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

`ifdef IPM_FIFO_RD_STREAM_CNT_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;

    assign beat_cnt = beat_cnt_q;

    always_comb begin
        beat_cnt_d = beat_cnt_q + 32'(pop);
        if (flush) begin
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    // The issue rule reserves a slot per request, so a capture into a full buffer is a design bug.
    a_no_cap_when_full: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
        !(cap && (lvl_q == SKID_LVL)));

endmodule

// File: tb/tb_ipm_distributed_fifo_rd_stream_v1_0.sv
// Testbench: two instances (RD_LATENCY 1 and 2) share one stimulus stream.
// Each instance has its own FIFO model with a fixed-latency read port and a
// scoreboard of words read but not yet delivered. A per-cycle monitor derives
// m_valid, buf_level and fifo_rd_en from that scoreboard, and it checks every
// accepted beat against the scoreboard head.
module tb_ipm_distributed_fifo_rd_stream_v1_0;

    localparam int DW = 32;

    typedef struct {
        int            c;  // cycle in which the read was issued
        logic [DW-1:0] d;
    } ent_t;

    logic          rd_clk   = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          flush    = 1'b0;
    logic          m_ready  = 1'b0;
    logic [DW-1:0] src[$];
    int            src_cnt  = 0;
    int            cyc      = 0;
    int            checks   = 0;
    int            errors   = 0;

    always #5 rd_clk = ~rd_clk;
    always @(posedge rd_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int lat, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d cyc=%0d actual=%h expected=%h", name, lat, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int RDL  = k + 1;
        localparam int SKID = RDL + 1;

        logic          fifo_empty;
        logic          fifo_rd_en;
        logic          m_valid;
        logic [DW-1:0] fifo_rd_data = '0;
        logic [DW-1:0] m_data;
        logic [1:0]    buf_level;
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
        logic [31:0]   beat_cnt;
        int            cnt_m = 0;
`endif
        int            rp = 0;
        int            pend = 0;
        logic          iss = 1'b0;
        logic [DW-1:0] iss_word = '0;
        logic [RDL-1:0] pv = '0;
        logic [DW-1:0] pd [RDL];
        ent_t          exp_q[$];
        logic          held = 1'b0;
        logic [DW-1:0] held_d = '0;

        assign fifo_empty = (rp >= src_cnt);

        ipm_distributed_fifo_rd_stream_v1_0 #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (RDL)
        ) u_dut (
            .rd_clk       (rd_clk),
            .rd_rst_n     (rd_rst_n),
            .fifo_empty   (fifo_empty),
            .fifo_rd_en   (fifo_rd_en),
            .fifo_rd_data (fifo_rd_data),
            .flush        (flush),
            .m_valid      (m_valid),
            .m_ready      (m_ready),
            .m_data       (m_data),
            .buf_level    (buf_level)
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
            ,
            .beat_cnt     (beat_cnt)
`endif
        );

        // FIFO model: the read data shows up RDL clocks after the request.
        // Otherwise the port shows random noise.
        always @(posedge rd_clk) begin
            #1;
            if (!rd_rst_n) begin
                pv  = '0;
                rp  = src_cnt;
                iss = 1'b0;
            end else begin
                for (int i = RDL - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pd[i] = pd[i-1];
                end
                pv[0] = iss;
                pd[0] = iss_word;
                if (iss) rp++;
                iss = 1'b0;
            end
            fifo_rd_data = pv[RDL-1] ? pd[RDL-1] : $urandom;
        end

        // Monitor: an entry issued in cycle c is deliverable from cycle c+RDL+1.
        always @(negedge rd_clk) begin
            int   lvl_m;
            int   occ_m;
            logic vld_m;
            logic pop_m;
            logic en_m;
            ent_t e;
            if (!rd_rst_n) begin
                exp_q.delete();
                held = 1'b0;
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
                cnt_m = 0;
`endif
            end
            lvl_m = 0;
            foreach (exp_q[i]) if (exp_q[i].c + RDL + 1 <= cyc) lvl_m++;
            vld_m = (lvl_m != 0);
            pop_m = vld_m && m_ready;
            occ_m = exp_q.size();
            en_m  = rd_rst_n && !fifo_empty && !flush && ((occ_m - int'(pop_m)) < SKID);
            chk("m_valid", RDL, DW'(m_valid), DW'(vld_m));
            chk("buf_level", RDL, DW'(buf_level), DW'(lvl_m));
            chk("fifo_rd_en", RDL, DW'(fifo_rd_en), DW'(en_m));
            if (!rd_rst_n) chk("m_data_rst", RDL, m_data, '0);
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
            chk("beat_cnt", RDL, beat_cnt, DW'(cnt_m));
`endif
            if (vld_m) begin
                chk("m_data", RDL, m_data, exp_q[0].d);
                if (held) chk("m_data_hold", RDL, m_data, held_d);
                held   = !m_ready;
                held_d = m_data;
                if (m_ready) begin
                    void'(exp_q.pop_front());
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
                    cnt_m++;
`endif
                end
            end else begin
                held = 1'b0;
            end
            if (fifo_rd_en && rd_rst_n && rp < src_cnt) begin
                iss      = 1'b1;
                iss_word = src[rp];
                e.c      = cyc;
                e.d      = src[rp];
                exp_q.push_back(e);
            end
            if (flush) begin
                exp_q.delete();
                held = 1'b0;
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
                cnt_m = 0;
`endif
            end
            pend = exp_q.size();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        src.push_back(w);
        src_cnt++;
    endtask

    initial begin
        // Reset: the monitor checks the cleared outputs while reset is held.
        step(3);
        rd_rst_n = 1'b1;
        step(2);

        // Preloaded burst with the sink always ready.
        for (int i = 0; i < 8; i++) push(DW'(32'h11 + i));
        m_ready = 1'b1;
        step(20);

        // Sixteen words while m_ready toggles every clock.
        for (int i = 0; i < 16; i++) push($urandom);
        for (int i = 0; i < 40; i++) begin
            m_ready = ~m_ready;
            step(1);
        end
        m_ready = 1'b1;
        step(10);

        // Stalled sink: reads must stop once the skid buffer is reserved.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push($urandom);
        step(10);
        m_ready = 1'b1;
        step(15);

        // Flush with a full buffer and reads in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push($urandom);
        step(5);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(3);
        m_ready = 1'b1;
        step(15);

        // Random traffic, back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) push($urandom);
            m_ready = ($urandom_range(3) != 0);
            flush   = ($urandom_range(40) == 0);
            step(1);
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        step(20);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 8; i++) push($urandom);
        step(3);
        #2;
        rd_rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 1, DW'(g_dut[0].m_valid), '0);
        chk("rst_async_valid", 2, DW'(g_dut[1].m_valid), '0);
        chk("rst_async_level", 1, DW'(g_dut[0].buf_level), '0);
        chk("rst_async_level", 2, DW'(g_dut[1].buf_level), '0);
        chk("rst_async_rd_en", 1, DW'(g_dut[0].fifo_rd_en), '0);
        chk("rst_async_rd_en", 2, DW'(g_dut[1].fifo_rd_en), '0);
`ifdef IPM_FIFO_RD_STREAM_CNT_EN
        chk("rst_async_cnt", 1, g_dut[0].beat_cnt, '0);
        chk("rst_async_cnt", 2, g_dut[1].beat_cnt, '0);
`endif
        step(3);
        rd_rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 6; i++) push($urandom);
        step(20);

        // Everything read from the FIFO must have been delivered.
        chk("drained", 1, DW'(g_dut[0].pend), '0);
        chk("drained", 2, DW'(g_dut[1].pend), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
